rv_fetch_ctrl: RTL and testbench
================================

RV_FETCH_CTRL -- requirements
Module: rv_fetch_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL be the fetch PC loaded on reset.
REQ-002 i_clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 i_reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 i_pc_select  input  1  SHALL be the redirect strobe (branch/jump/trap).
REQ-005 i_pc_target  input  32  SHALL be the redirect address, valid with i_pc_select; bit 0 ignored.
REQ-006 i_buf_free_dword  input  1  SHALL indicate the instruction buffer can accept at least one 32-bit word.
REQ-007 i_pc_incr  input  32  SHALL be the buffer-supplied PC advance for the current response; legal values 2 or 4.
REQ-008 o_bus_req  output  1  SHALL be the instruction-bus request, held high until acknowledged.
REQ-009 o_bus_addr  output  32  SHALL be the word-aligned request address, bits [1:0] = 0.
REQ-010 i_bus_ack  input  1  SHALL indicate request completion; i_bus_data valid in the same cycle.
REQ-011 i_bus_data  input  32  SHALL be the fetched word.
REQ-012 o_ack  output  1  SHALL tell the buffer that o_data is a valid, non-stale word.
REQ-013 o_data  output  32  SHALL carry i_bus_data unchanged.
REQ-014 o_fetch_pc1  output  1  SHALL be bit 1 of the current fetch PC.
REQ-015 o_fetch_pc_next  output  32  SHALL equal i_pc_target when i_pc_select = 1, else the current fetch PC.
REQ-016 o_pc_select  output  1  SHALL be i_pc_select passed through combinationally.

Function
REQ-017 The block SHALL keep a 32-bit fetch PC register (pc) and a 32-bit address register (addr_q).
REQ-018 FSM states SHALL be IDLE, REQ and KILL; o_bus_req = 1 in REQ and KILL only; o_bus_addr = addr_q.
REQ-019 IDLE: if i_buf_free_dword = 1 and i_pc_select = 0, the FSM SHALL go to REQ and latch addr_q = {pc[31:2],2'b00}; otherwise it stays in IDLE.
REQ-020 REQ with i_bus_ack = 1 and i_pc_select = 0: o_ack = 1, pc <= pc + i_pc_incr (modulo 2^32), next state IDLE.
REQ-021 REQ with i_bus_ack = 1 and i_pc_select = 1: o_ack = 0, pc <= i_pc_target, next state IDLE.
REQ-022 REQ with i_bus_ack = 0 and i_pc_select = 1: pc <= i_pc_target, next state KILL; addr_q and o_bus_req SHALL stay unchanged.
REQ-023 KILL: o_ack SHALL be 0; on i_bus_ack the FSM SHALL go to IDLE and discard the data.
REQ-024 A redirect in KILL or IDLE SHALL update pc to i_pc_target and SHALL NOT change state.
REQ-025 o_ack SHALL be 0 in every cycle without i_bus_ack, in KILL, and in any cycle with i_pc_select = 1.
REQ-026 At most one bus request SHALL be outstanding; addr_q SHALL be stable while o_bus_req = 1.
REQ-027 Minimum issue latency SHALL be 1 cycle (IDLE to REQ); peak throughput SHALL be one word every 2 cycles, with a zero-wait bus.
REQ-028 i_buf_free_dword SHALL be sampled only in IDLE; deassertion during REQ SHALL NOT abort a request.
REQ-029 pc SHALL wrap from 32'hFFFF_FFFC + 4 to 32'h0000_0000 without error.

Reset
REQ-030 While i_reset = 1 at a clock edge: state <= IDLE, pc <= RESET_VECTOR, addr_q <= 0.
REQ-031 During and after reset: o_bus_req = 0 and o_ack = 0; o_data follows i_bus_data.
REQ-032 Reset SHALL take priority over i_pc_select and i_bus_ack.
REQ-033 Reset asserted in REQ or KILL SHALL drop o_bus_req; a later i_bus_ack for that request SHALL be ignored (o_ack = 0 in IDLE).

Verification
REQ-034 Reset, RESET_VECTOR = 32'h100, free = 1, ack 1 cycle after req, i_pc_incr = 4 -> bus addresses 0x100, 0x104, 0x108 on alternate cycles; o_ack pulses with each word.
REQ-035 pc = 0x102, i_pc_incr = 2 -> o_bus_addr = 0x100, o_fetch_pc1 = 1; after ack, pc = 0x104 and next address = 0x104.
REQ-036 Redirect to 0x200 while in REQ, ack 3 cycles later -> KILL entered, o_bus_addr held, stale ack gives o_ack = 0, next request address = 0x200.
REQ-037 Redirect to 0x300 in the same cycle as ack -> o_ack = 0, o_fetch_pc_next = 0x300, next request address = 0x300.
REQ-038 i_buf_free_dword = 0 for 5 cycles in IDLE -> o_bus_req stays 0; free = 1 -> o_bus_req = 1 on the next cycle.
REQ-039 Reset asserted mid-REQ, then ack arrives -> o_bus_req = 0, o_ack = 0, pc = RESET_VECTOR.

Source files
------------

// File: rtl/rv_fetch_ctrl.sv
// rv_fetch_ctrl
// Instruction fetch controller. Keeps the fetch PC, issues one word-aligned
// instruction-bus request at a time when the instruction buffer has room,
// and forwards returned words to the buffer. If a redirect arrives while a
// request is still in flight, that request is left to complete and its data
// is thrown away.
//
// Ports
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_pc_select          redirect strobe (branch/jump/trap)
//   i_pc_target          redirect address (bit 0 ignored when loaded into pc)
//   i_buf_free_dword     buffer can take at least one 32-bit word
//   i_pc_incr            PC advance for the current response (2 or 4)
//   o_bus_req/o_bus_addr instruction-bus request and word-aligned address
//   i_bus_ack/i_bus_data bus completion and fetched word
//   o_ack/o_data         valid, non-stale word to the buffer
//   o_fetch_pc1          bit 1 of the fetch PC
//   o_fetch_pc_next      redirect target if redirecting, else fetch PC
//   o_pc_select          redirect strobe passed through
//
// state | meaning
// IDLE  | no request outstanding; waiting for buffer space
// REQ   | request outstanding; its data is wanted
// KILL  | request outstanding; redirected, data is discarded on ack

module rv_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pc_select,
  input  logic [31:0] i_pc_target,
  input  logic        i_buf_free_dword,
  input  logic [31:0] i_pc_incr,
  output logic        o_bus_req,
  output logic [31:0] o_bus_addr,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_data,
  output logic        o_ack,
  output logic [31:0] o_data,
  output logic        o_fetch_pc1,
  output logic [31:0] o_fetch_pc_next,
  output logic        o_pc_select
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_KILL = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        bus_req_q, bus_req_d;
  logic [31:0] target_even;

  assign target_even = {i_pc_target[31:1], 1'b0};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    bus_req_d = bus_req_q;
    case (state_q)
      S_IDLE: begin
        if (i_pc_select) begin
          pc_d = target_even;
        end else if (i_buf_free_dword) begin
          state_d   = S_REQ;
          addr_d    = {pc_q[31:2], 2'b00};
          bus_req_d = 1'b1;
        end
      end
      S_REQ: begin
        if (i_bus_ack) begin
          state_d   = S_IDLE;
          bus_req_d = 1'b0;
          pc_d      = i_pc_select ? target_even : pc_q + i_pc_incr;
        end else if (i_pc_select) begin
          // Request stays on the bus with its original address.
          state_d = S_KILL;
          pc_d    = target_even;
        end
      end
      S_KILL: begin
        if (i_pc_select) begin
          pc_d = target_even;
        end
        if (i_bus_ack) begin
          state_d   = S_IDLE;
          bus_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_VECTOR;
      addr_q    <= 32'h0;
      bus_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      bus_req_q <= bus_req_d;
    end
  end

  // Reset masks the request and ack in the reset cycle itself, before the
  // registers have been cleared.
  assign o_bus_req       = bus_req_q & ~i_reset;
  assign o_bus_addr      = addr_q;
  assign o_ack           = (state_q == S_REQ) & i_bus_ack & ~i_pc_select & ~i_reset;
  assign o_data          = i_bus_data;
  assign o_fetch_pc1     = pc_q[1];
  assign o_fetch_pc_next = i_pc_select ? i_pc_target : pc_q;
  assign o_pc_select     = i_pc_select;

endmodule

// File: tb/tb_rv_fetch_ctrl.sv
module tb_rv_fetch_ctrl;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        sel;
  logic [31:0] tgt;
  logic        free;
  logic [31:0] incr;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_ack;
  logic [31:0] bus_data;
  logic        ack;
  logic [31:0] data;
  logic        pc1;
  logic [31:0] pc_next;
  logic        pc_sel_o;

  int n_vec  = 0;
  int n_miss = 0;

  rv_fetch_ctrl #(.RESET_VECTOR(RV)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_pc_select     (sel),
    .i_pc_target     (tgt),
    .i_buf_free_dword(free),
    .i_pc_incr       (incr),
    .o_bus_req       (bus_req),
    .o_bus_addr      (bus_addr),
    .i_bus_ack       (bus_ack),
    .i_bus_data      (bus_data),
    .o_ack           (ack),
    .o_data          (data),
    .o_fetch_pc1     (pc1),
    .o_fetch_pc_next (pc_next),
    .o_pc_select     (pc_sel_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Abstract model: fetch PC, whether a bus transaction is in flight,
  // whether its data has been made stale by a redirect, and its address.
  logic [31:0] m_pc;
  logic        m_busy;
  logic        m_stale;
  logic [31:0] m_addr;
  logic        m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc    = RV;
      m_busy  = 1'b0;
      m_stale = 1'b0;
      m_addr  = 32'h0;
      m_valid = 1'b1;
    end else if (!m_busy) begin
      if (sel) m_pc = tgt & 32'hFFFF_FFFE;
      else if (free) begin
        m_busy  = 1'b1;
        m_stale = 1'b0;
        m_addr  = m_pc & 32'hFFFF_FFFC;
      end
    end else begin
      if (sel) m_pc = tgt & 32'hFFFF_FFFE;
      else if (bus_ack && !m_stale) m_pc = m_pc + incr;
      if (bus_ack) m_busy = 1'b0;
      else if (sel) m_stale = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("bus_req", {31'b0, bus_req}, {31'b0, m_busy && !rst});
      check("bus_addr", bus_addr, m_addr);
      check("ack", {31'b0, ack}, {31'b0, m_busy && !m_stale && bus_ack && !sel && !rst});
      check("data", data, bus_data);
      check("fetch_pc1", {31'b0, pc1}, {31'b0, m_pc[1]});
      check("pc_next", pc_next, sel ? tgt : m_pc);
      check("pc_select", {31'b0, pc_sel_o}, {31'b0, sel});
    end
  end

  task automatic drive(input logic r, input logic f, input logic s, input logic [31:0] t,
                       input logic a, input logic [31:0] inc);
    rst      = r;
    free     = f;
    sel      = s;
    tgt      = t;
    bus_ack  = a;
    incr     = inc;
    bus_data = $urandom;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 1, 0, 0, 1, 4);
    cyc();
    cyc();

    // Idle after reset
    drive(0, 1, 0, 0, 1, 4);
    #1;
    check("lit_rst_req", {31'b0, bus_req}, 32'd0);
    check("lit_rst_pc", pc_next, 32'h100);

    // Streaming: addresses 0x100, 0x104, 0x108 on alternate cycles
    for (int k = 0; k < 6; k++) begin
      drive(0, 1, 0, 0, 1, 4);
      #1;
      if (k % 2 == 1) begin
        check("lit_stream_req", {31'b0, bus_req}, 32'd1);
        check("lit_stream_addr", bus_addr, 32'h100 + 32'(2 * (k - 1)));
        check("lit_stream_ack", {31'b0, ack}, 32'd1);
      end
      cyc();
    end

    // Halfword PC 0x102 with incr 2
    drive(0, 1, 1, 32'h102, 0, 4); cyc();
    drive(0, 1, 0, 0, 0, 4); cyc();
    drive(0, 1, 0, 0, 0, 4); #1;
    check("lit_half_addr", bus_addr, 32'h100);
    check("lit_half_pc1", {31'b0, pc1}, 32'd1);
    cyc();
    drive(0, 1, 0, 0, 1, 2); #1;
    check("lit_half_ack", {31'b0, ack}, 32'd1);
    cyc();
    drive(0, 1, 0, 0, 0, 4); #1;
    check("lit_half_pcnext", pc_next, 32'h104);
    cyc();
    drive(0, 1, 0, 0, 1, 4); #1;
    check("lit_half_addr2", bus_addr, 32'h104);
    cyc();

    // Redirect during REQ, stale ack three cycles later
    drive(0, 1, 0, 0, 0, 4); cyc();
    drive(0, 1, 1, 32'h200, 0, 4); cyc();
    drive(0, 1, 0, 0, 0, 4); #1;
    check("lit_kill_req", {31'b0, bus_req}, 32'd1);
    check("lit_kill_addr", bus_addr, 32'h108);
    cyc();
    drive(0, 1, 0, 0, 0, 4); cyc();
    drive(0, 1, 0, 0, 1, 4); #1;
    check("lit_kill_ack", {31'b0, ack}, 32'd0);
    check("lit_kill_req2", {31'b0, bus_req}, 32'd1);
    cyc();
    drive(0, 1, 0, 0, 0, 4); cyc();
    drive(0, 1, 0, 0, 1, 4); #1;
    check("lit_kill_newaddr", bus_addr, 32'h200);
    cyc();

    // Redirect in the same cycle as ack
    drive(0, 1, 0, 0, 0, 4); cyc();
    drive(0, 1, 1, 32'h300, 1, 4); #1;
    check("lit_same_ack", {31'b0, ack}, 32'd0);
    check("lit_same_pcnext", pc_next, 32'h300);
    cyc();
    drive(0, 1, 0, 0, 0, 4); cyc();
    drive(0, 1, 0, 0, 1, 4); #1;
    check("lit_same_addr", bus_addr, 32'h300);
    cyc();

    // Buffer full for 5 cycles, then free; free drops during REQ
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 0, 0, 4); #1;
      check("lit_full_req", {31'b0, bus_req}, 32'd0);
      cyc();
    end
    drive(0, 1, 0, 0, 0, 4); cyc();
    drive(0, 0, 0, 0, 0, 4); #1;
    check("lit_free_req", {31'b0, bus_req}, 32'd1);
    check("lit_free_addr", bus_addr, 32'h304);
    cyc();
    drive(0, 0, 0, 0, 0, 4); cyc();
    drive(0, 0, 0, 0, 1, 4); #1;
    check("lit_free_ack", {31'b0, ack}, 32'd1);
    cyc();

    // Reset mid-REQ, ack arrives afterwards
    drive(0, 1, 0, 0, 0, 4); cyc();
    drive(1, 1, 0, 0, 0, 4); #1;
    check("lit_midrst_req", {31'b0, bus_req}, 32'd0);
    cyc();
    drive(0, 0, 0, 0, 1, 4); #1;
    check("lit_midrst_ack", {31'b0, ack}, 32'd0);
    check("lit_midrst_req2", {31'b0, bus_req}, 32'd0);
    check("lit_midrst_pc", pc_next, 32'h100);
    cyc();

    // PC wrap
    drive(0, 0, 1, 32'hFFFF_FFFC, 0, 4); cyc();
    drive(0, 1, 0, 0, 0, 4); cyc();
    drive(0, 1, 0, 0, 1, 4); #1;
    check("lit_wrap_addr", bus_addr, 32'hFFFF_FFFC);
    cyc();
    drive(0, 0, 0, 0, 0, 4); #1;
    check("lit_wrap_pc", pc_next, 32'h0);
    cyc();

    // Reset beats redirect; target bit 0 dropped
    drive(1, 1, 1, 32'h500, 1, 4); cyc();
    drive(0, 0, 0, 0, 0, 4); #1;
    check("lit_rstprio_pc", pc_next, 32'h100);
    cyc();
    drive(0, 0, 1, 32'h401, 0, 4); cyc();
    drive(0, 0, 0, 0, 0, 4); #1;
    check("lit_bit0_pc", pc_next, 32'h400);
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
